// File: rtl/lcd_progress_bar.sv
`default_nettype none
// ============================================================================
// Module   : lcd_progress_bar
// Brief    : Draws a horizontal progress bar on an ST7735 panel as a stream of
//            9-bit command/data bytes on the LCD byte-writer handshake.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_progress_bar #(
    parameter int X0       = 10,
    parameter int Y0       = 100,
    parameter int SEG_W    = 7,
    parameter int PROC_MAX = 20,
    parameter int BAR_H    = 6
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_done,
    input  logic [4:0]  process,
    input  logic        force_redraw,
    input  logic [15:0] fg_color,
    input  logic [15:0] bg_color,
    input  logic        wr_done,
    output logic [8:0]  spi_data,
    output logic        en_write,
    output logic        busy,
    output logic        draw_done
);

    localparam int c_bar_w = SEG_W * PROC_MAX;
    localparam int c_col_w = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;
    localparam int c_row_w = (BAR_H > 1) ? $clog2(BAR_H) : 1;

    localparam logic [7:0] c_x0 = 8'(X0);
    localparam logic [7:0] c_x1 = 8'(X0 + c_bar_w - 1);
    localparam logic [7:0] c_y0 = 8'(Y0);
    localparam logic [7:0] c_y1 = 8'(Y0 + BAR_H - 1);

    localparam logic [3:0]         c_last_hdr = 4'd10;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(c_bar_w - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(BAR_H - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_SEND = 3'd1,
        ST_HDR_WAIT = 3'd2,
        ST_PIX_SEND = 3'd3,
        ST_PIX_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t             r_state,  w_state;
    logic [3:0]         r_hdr_idx, w_hdr_idx;
    logic [c_col_w-1:0] r_col,    w_col;
    logic [c_row_w-1:0] r_row,    w_row;
    logic               r_phase,  w_phase;
    logic [4:0]         r_proc_l, w_proc_l;
    logic [15:0]        r_fg,     w_fg;
    logic [15:0]        r_bg,     w_bg;
    logic               r_pending, w_pending;
    logic               r_drawn_valid, w_drawn_valid;
    logic [8:0]         r_spi_data, w_spi_data;

    logic               w_start;
    logic               w_abort;
    logic [4:0]         w_proc_clamped;
    logic [15:0]        w_fill;

    assign w_proc_clamped = (int'(process) > PROC_MAX) ? 5'(PROC_MAX) : process;
    assign w_fill         = 16'(r_proc_l) * 16'(SEG_W);

    // CASET / RASET / RAMWR preamble, indexed by byte position
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx);
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, 8'h2A};
            4'd1:    b = {1'b1, 8'h00};
            4'd2:    b = {1'b1, c_x0};
            4'd3:    b = {1'b1, 8'h00};
            4'd4:    b = {1'b1, c_x1};
            4'd5:    b = {1'b0, 8'h2B};
            4'd6:    b = {1'b1, 8'h00};
            4'd7:    b = {1'b1, c_y0};
            4'd8:    b = {1'b1, 8'h00};
            4'd9:    b = {1'b1, c_y1};
            default: b = {1'b0, 8'h2C};
        endcase
        return b;
    endfunction

    function automatic logic [8:0] pix_byte(input logic [c_col_w-1:0] col,
                                            input logic               lo,
                                            input logic [15:0]        fill,
                                            input logic [15:0]        fg,
                                            input logic [15:0]        bg);
        logic [15:0] colour;
        colour = (16'(col) < fill) ? fg : bg;
        return lo ? {1'b1, colour[7:0]} : {1'b1, colour[15:8]};
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= ST_IDLE;
            r_hdr_idx     <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_phase       <= 1'b0;
            r_proc_l      <= '0;
            r_fg          <= '0;
            r_bg          <= '0;
            r_pending     <= 1'b1;
            r_drawn_valid <= 1'b0;
            r_spi_data    <= '0;
        end else begin
            r_state       <= w_state;
            r_hdr_idx     <= w_hdr_idx;
            r_col         <= w_col;
            r_row         <= w_row;
            r_phase       <= w_phase;
            r_proc_l      <= w_proc_l;
            r_fg          <= w_fg;
            r_bg          <= w_bg;
            r_pending     <= w_pending;
            r_drawn_valid <= w_drawn_valid;
            r_spi_data    <= w_spi_data;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_hdr_idx     = r_hdr_idx;
        w_col         = r_col;
        w_row         = r_row;
        w_phase       = r_phase;
        w_proc_l      = r_proc_l;
        w_fg          = r_fg;
        w_bg          = r_bg;
        w_pending     = r_pending;
        w_drawn_valid = r_drawn_valid;
        w_spi_data    = r_spi_data;
        w_start       = 1'b0;
        w_abort       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (init_done && r_pending) begin
                    w_start    = 1'b1;
                    w_proc_l   = w_proc_clamped;
                    w_fg       = fg_color;
                    w_bg       = bg_color;
                    w_hdr_idx  = '0;
                    w_spi_data = hdr_byte(4'd0);
                    w_state    = ST_HDR_SEND;
                end
            end
            ST_HDR_SEND: w_state = ST_HDR_WAIT;
            ST_HDR_WAIT: begin
                if (wr_done) begin
                    if (r_hdr_idx == c_last_hdr) begin
                        w_col      = '0;
                        w_row      = '0;
                        w_phase    = 1'b0;
                        w_spi_data = pix_byte('0, 1'b0, w_fill, r_fg, r_bg);
                    end else begin
                        w_hdr_idx  = r_hdr_idx + 4'd1;
                        w_spi_data = hdr_byte(r_hdr_idx + 4'd1);
                    end
                    w_state = (r_hdr_idx == c_last_hdr) ? ST_PIX_SEND : ST_HDR_SEND;
                end
            end
            ST_PIX_SEND: w_state = ST_PIX_WAIT;
            ST_PIX_WAIT: begin
                if (wr_done) begin
                    w_state = ST_PIX_SEND;
                    if (!r_phase) begin
                        w_phase    = 1'b1;
                        w_spi_data = pix_byte(r_col, 1'b1, w_fill, r_fg, r_bg);
                    end else begin
                        w_phase = 1'b0;
                        if (r_col == c_col_last) begin
                            w_col = '0;
                            if (r_row == c_row_last) begin
                                // last low byte of the last row acknowledged
                                w_state       = ST_DONE;
                                w_drawn_valid = 1'b1;
                                w_spi_data    = '0;
                            end else begin
                                w_row      = r_row + c_row_w'(1);
                                w_spi_data = pix_byte('0, 1'b0, w_fill, r_fg, r_bg);
                            end
                        end else begin
                            w_col      = r_col + c_col_w'(1);
                            w_spi_data = pix_byte(r_col + c_col_w'(1), 1'b0, w_fill, r_fg, r_bg);
                        end
                    end
                end
            end
            ST_DONE: w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase

        // Losing the panel mid-draw abandons the bar; it is redrawn once init returns
        if (!init_done && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
            w_abort       = 1'b1;
            w_state       = ST_IDLE;
            w_drawn_valid = 1'b0;
            w_spi_data    = '0;
        end

        // r_proc_l doubles as the last drawn value once a draw has completed
        if (w_start) begin
            w_pending = 1'b0;
        end else if (w_abort || force_redraw || (w_proc_clamped != r_proc_l) ||
                     ((r_state == ST_IDLE) && !r_drawn_valid)) begin
            w_pending = 1'b1;
        end
    end

    assign spi_data  = r_spi_data;
    assign en_write  = (r_state == ST_HDR_SEND) || (r_state == ST_PIX_SEND);
    assign busy      = (r_state == ST_HDR_SEND) || (r_state == ST_HDR_WAIT) ||
                       (r_state == ST_PIX_SEND) || (r_state == ST_PIX_WAIT);
    assign draw_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_progress_bar.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_progress_bar
// Brief    : Self-checking bench for lcd_progress_bar with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_progress_bar;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [4:0]  process;
    logic        force_redraw;
    logic [15:0] fg_color;
    logic [15:0] bg_color;
    logic        wr_done;
    logic [8:0]  spi_data;
    logic        en_write;
    logic        busy;
    logic        draw_done;

    int   total       = 0;
    int   bad         = 0;
    int   done_cnt    = 0;
    int   bytes_total = 0;
    int   resp_delay  = 3;
    logic hold        = 1'b0;

    logic [8:0] exp_q [$];
    logic [8:0] hdr_tab [11];

    typedef struct {
        logic [4:0]  proc_in;
        logic        force_in;
        logic [15:0] fg;
        logic [15:0] bg;
        int          exp_proc;
        int          exp_draws;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    lcd_progress_bar dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .init_done    (init_done),
        .process      (process),
        .force_redraw (force_redraw),
        .fg_color     (fg_color),
        .bg_color     (bg_color),
        .wr_done      (wr_done),
        .spi_data     (spi_data),
        .en_write     (en_write),
        .busy         (busy),
        .draw_done    (draw_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected bytes of one full bar: preamble then row-major pixels, high byte first
    task automatic push_draw(input int p, input logic [15:0] fg, input logic [15:0] bg);
        logic [15:0] c;
        for (int i = 0; i < 11; i++) exp_q.push_back(hdr_tab[i]);
        for (int r = 0; r < 6; r++) begin
            for (int col = 0; col < 140; col++) begin
                c = (col < p * 7) ? fg : bg;
                exp_q.push_back({1'b1, c[15:8]});
                exp_q.push_back({1'b1, c[7:0]});
            end
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (bytes_total < n && k < budget) begin
            tick();
            k++;
        end
        check("bytes_reached", {31'b0, bytes_total >= n}, 1);
    endtask

    // Byte-writer model: compares each byte against the scoreboard and answers with wr_done
    initial begin : responder
        logic [8:0] last_byte;
        logic       outstanding;
        int         cnt;
        last_byte   = '0;
        outstanding = 1'b0;
        cnt         = 0;
        wr_done     = 1'b0;
        forever begin
            @(negedge clk);
            if (draw_done) done_cnt++;
            if (wr_done) begin
                wr_done     = 1'b0;
                outstanding = 1'b0;
            end
            if (hold) outstanding = 1'b0;
            if (en_write) begin
                check("en_write_before_wr_done", {31'b0, outstanding}, 0);
                bytes_total++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %03h expected no byte", spi_data);
                end else begin
                    check("spi_byte", {23'b0, spi_data}, {23'b0, exp_q.pop_front()});
                end
                last_byte   = spi_data;
                outstanding = 1'b1;
                cnt         = resp_delay;
            end else if (outstanding) begin
                check("spi_data_held", {23'b0, spi_data}, {23'b0, last_byte});
                cnt--;
                if (cnt <= 0) wr_done = 1'b1;
            end
        end
    end

    initial begin : main
        int base;
        int b0;

        hdr_tab[0]  = 9'h02A; hdr_tab[1]  = 9'h100; hdr_tab[2]  = 9'h10A;
        hdr_tab[3]  = 9'h100; hdr_tab[4]  = 9'h195; hdr_tab[5]  = 9'h02B;
        hdr_tab[6]  = 9'h100; hdr_tab[7]  = 9'h164; hdr_tab[8]  = 9'h100;
        hdr_tab[9]  = 9'h169; hdr_tab[10] = 9'h02C;

        //           proc   force  fg        bg        exp  draws
        vecs[0] = '{5'd0,  1'b0, 16'hF800, 16'h001F, 0,  1};
        vecs[1] = '{5'd10, 1'b0, 16'hF800, 16'h001F, 10, 1};
        vecs[2] = '{5'd25, 1'b0, 16'h07E0, 16'hFFFF, 20, 1};
        vecs[3] = '{5'd25, 1'b0, 16'h1111, 16'h2222, 20, 0};
        vecs[4] = '{5'd20, 1'b0, 16'h07E0, 16'hFFFF, 20, 0};
        vecs[5] = '{5'd20, 1'b1, 16'h1234, 16'hABCD, 20, 1};
        vecs[6] = '{5'd1,  1'b0, 16'hABCD, 16'h1234, 1,  1};
        vecs[7] = '{5'd19, 1'b0, 16'h5A5A, 16'hA5A5, 19, 1};

        rst          = 1'b1;
        init_done    = 1'b0;
        force_redraw = 1'b0;
        process      = '0;
        fg_color     = '0;
        bg_color     = '0;
        repeat (3) tick();
        check("rst_en_write",  {31'b0, en_write}, 0);
        check("rst_busy",      {31'b0, busy}, 0);
        check("rst_draw_done", {31'b0, draw_done}, 0);
        check("rst_spi_data",  {23'b0, spi_data}, 0);
        rst = 1'b0;

        // Panel not initialised: the bar must stay silent
        repeat (50) begin
            tick();
            check("noinit_en_write", {31'b0, en_write}, 0);
            check("noinit_busy",     {31'b0, busy}, 0);
            check("noinit_spi_data", {23'b0, spi_data}, 0);
        end

        for (int i = 0; i < 8; i++) begin
            if (i > 0) resp_delay = 1;
            base = done_cnt;
            b0   = bytes_total;
            if (vecs[i].exp_draws > 0) push_draw(vecs[i].exp_proc, vecs[i].fg, vecs[i].bg);
            process      = vecs[i].proc_in;
            fg_color     = vecs[i].fg;
            bg_color     = vecs[i].bg;
            force_redraw = vecs[i].force_in;
            init_done    = 1'b1;
            tick();
            force_redraw = 1'b0;
            if (vecs[i].exp_draws > 0) wait_done(base + 1, 12000);
            repeat (200) tick();
            check($sformatf("vec%0d_draws", i), done_cnt - base, vecs[i].exp_draws);
            check($sformatf("vec%0d_bytes", i), bytes_total - b0, vecs[i].exp_draws * 1691);
            check($sformatf("vec%0d_queue_empty", i), exp_q.size(), 0);
        end

        // Changes during a draw collapse into one follow-up draw with the latest value
        base = done_cnt;
        b0   = bytes_total;
        push_draw(3, 16'h7BEF, 16'h0841);
        fg_color = 16'h7BEF;
        bg_color = 16'h0841;
        process  = 5'd3;
        tick();
        wait_bytes(b0 + 200, 2000);
        check("busy_mid_draw", {31'b0, busy}, 1);
        process = 5'd4;
        repeat (50) tick();
        process = 5'd5;
        push_draw(5, 16'h7BEF, 16'h0841);
        wait_done(base + 2, 20000);
        repeat (200) tick();
        check("collapse_draws", done_cnt - base, 2);
        check("collapse_bytes", bytes_total - b0, 2 * 1691);
        check("collapse_queue_empty", exp_q.size(), 0);

        // init_done drops at byte 500 while wr_done is withheld
        base = done_cnt;
        b0   = bytes_total;
        push_draw(9, 16'hFFE0, 16'h0000);
        fg_color = 16'hFFE0;
        bg_color = 16'h0000;
        process  = 5'd9;
        tick();
        wait_bytes(b0 + 500, 3000);
        hold      = 1'b1;
        init_done = 1'b0;
        repeat (20) begin
            tick();
            check("abort_en_write", {31'b0, en_write}, 0);
            check("abort_busy",     {31'b0, busy}, 0);
        end
        check("abort_no_draw_done", done_cnt - base, 0);
        check("abort_bytes", bytes_total - b0, 500);
        exp_q.delete();
        b0 = bytes_total;
        push_draw(9, 16'hFFE0, 16'h0000);
        hold      = 1'b0;
        init_done = 1'b1;
        wait_done(base + 1, 12000);
        repeat (50) tick();
        check("reinit_draws", done_cnt - base, 1);
        check("reinit_bytes", bytes_total - b0, 1691);
        check("reinit_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a forced draw
        base = done_cnt;
        b0   = bytes_total;
        push_draw(9, 16'hFFE0, 16'h0000);
        force_redraw = 1'b1;
        tick();
        force_redraw = 1'b0;
        wait_bytes(b0 + 30, 1000);
        rst  = 1'b1;
        hold = 1'b1;
        tick();
        check("midrst_en_write",  {31'b0, en_write}, 0);
        check("midrst_busy",      {31'b0, busy}, 0);
        check("midrst_draw_done", {31'b0, draw_done}, 0);
        check("midrst_spi_data",  {23'b0, spi_data}, 0);
        tick();
        exp_q.delete();
        b0 = bytes_total;
        push_draw(9, 16'hFFE0, 16'h0000);
        hold = 1'b0;
        rst  = 1'b0;
        wait_done(base + 1, 12000);
        repeat (50) tick();
        check("postrst_draws", done_cnt - base, 1);
        check("postrst_bytes", bytes_total - b0, 1691);
        check("postrst_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
